// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter and sequencer sharing one RSA modular-exponentiation engine
// among NREQ requesters, with a watchdog on the engine's done pulse.
//
// state | meaning
// IDLE  | pick next requester after Grant_id, latch its operands
// ISSUE | Eng_start pulse, arm watchdog
// WAIT  | wait for Eng_done or watchdog expiry
// RESP  | one-cycle Ack to granted requester, Result/Err valid
module rsa_job_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int TIMEOUT = 4095
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ*W-1:0]         Msg_in,
    input  logic [NREQ*W-1:0]         Priv_in,
    input  logic [NREQ*W-1:0]         Pub_in,
    output logic [NREQ-1:0]           Ack,
    output logic [W-1:0]              Result,
    output logic                      Err,
    output logic [$clog2(NREQ)-1:0]   Grant_id,
    output logic                      Busy,
    output logic                      Eng_start,
    output logic [W-1:0]              Eng_msg,
    output logic [W-1:0]              Eng_priv,
    output logic [W-1:0]              Eng_pub,
    input  logic                      Eng_done,
    input  logic [W-1:0]              Eng_val
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t          state;
    logic [CW-1:0]   wd_cnt;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   cand;
    logic [NREQ-1:0] ack_vec;

    // Search starts just after the last grant, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = Grant_id;
        cand       = Grant_id;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(Grant_id) + k) % NREQ);
            if (!pick_found && Req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign ack_vec = {{(NREQ-1){1'b0}}, 1'b1} << Grant_id;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            Ack       <= '0;
            Result    <= '0;
            Err       <= 1'b0;
            Busy      <= 1'b0;
            Eng_start <= 1'b0;
            Eng_msg   <= '0;
            Eng_priv  <= '0;
            Eng_pub   <= '0;
            Grant_id  <= GW'(NREQ - 1);
            wd_cnt    <= '0;
        end else begin
            Ack       <= '0;
            Eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        Grant_id  <= pick_idx;
                        Eng_msg   <= Msg_in[int'(pick_idx)*W +: W];
                        Eng_priv  <= Priv_in[int'(pick_idx)*W +: W];
                        Eng_pub   <= Pub_in[int'(pick_idx)*W +: W];
                        Eng_start <= 1'b1;
                        Busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Watchdog counts down; terminal count 0 is the last WAIT cycle.
                    wd_cnt <= CW'(TIMEOUT - 1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (Eng_done) begin
                        Result <= Eng_val;
                        Err    <= 1'b0;
                        Ack    <= ack_vec;
                        state  <= S_RESP;
                    end else if (wd_cnt == '0) begin
                        Result <= '0;
                        Err    <= 1'b1;
                        Ack    <= ack_vec;
                        state  <= S_RESP;
                    end else begin
                        wd_cnt <= wd_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: job-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rsa_job_arbiter;

    localparam int NREQ    = 4;
    localparam int W       = 16;
    localparam int TIMEOUT = 16;

    logic              Clk;
    logic              Reset;
    logic [NREQ-1:0]   Req;
    logic [NREQ*W-1:0] Msg_in, Priv_in, Pub_in;
    logic [NREQ-1:0]   Ack;
    logic [W-1:0]      Result;
    logic              Err;
    logic [1:0]        Grant_id;
    logic              Busy;
    logic              Eng_start;
    logic [W-1:0]      Eng_msg, Eng_priv, Eng_pub;
    logic              Eng_done;
    logic [W-1:0]      Eng_val;

    rsa_job_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req),
        .Msg_in(Msg_in), .Priv_in(Priv_in), .Pub_in(Pub_in),
        .Ack(Ack), .Result(Result), .Err(Err), .Grant_id(Grant_id), .Busy(Busy),
        .Eng_start(Eng_start), .Eng_msg(Eng_msg), .Eng_priv(Eng_priv), .Eng_pub(Eng_pub),
        .Eng_done(Eng_done), .Eng_val(Eng_val)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 0;

    logic [W-1:0] msg_a [NREQ];
    logic [W-1:0] priv_a[NREQ];
    logic [W-1:0] pub_a [NREQ];

    // engine model controls
    int  eng_lat = 0;     // 0 = never answers
    int  eng_fn  = 0;     // 0 modexp, 1 msg+100, 2 constant 7
    bit  eng_pend = 0;
    int  done_at = 0;
    logic [W-1:0] eng_res = '0;
    bit  stray = 0;

    // reference model
    bit           m_job, m_resp;
    int           m_age, m_grant;
    logic [W-1:0] m_result, m_msg, m_priv, m_pub;
    logic         m_err;

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    initial forever begin
        @(posedge Clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
        longint acc, base;
        if (n == 0) return '0;
        acc  = 1;
        base = longint'(m) % longint'(n);
        for (int b = 0; b < W; b++) begin
            if (e[b]) acc = (acc * base) % longint'(n);
            base = (base * base) % longint'(n);
        end
        return W'(acc);
    endfunction

    function automatic int rr_next(input int g, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++)
            if (r[(g + k) % NREQ]) return (g + k) % NREQ;
        return g;
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] m, input logic [W-1:0] p,
                           input logic [W-1:0] k);
        msg_a[i] = m; priv_a[i] = p; pub_a[i] = k;
        Msg_in[i*W +: W]  = m;
        Priv_in[i*W +: W] = p;
        Pub_in[i*W +: W]  = k;
    endtask

    // Engine: answers eng_lat cycles after the start pulse; shares Reset.
    initial begin
        Eng_done = 0;
        Eng_val  = '0;
        forever begin
            @(negedge Clk);
            Eng_done = 0;
            if (Reset) begin
                eng_pend = 0;
            end else if (stray) begin
                Eng_done = 1;
                Eng_val  = 16'd55;
                stray    = 0;
            end else if (Eng_start && eng_lat > 0) begin
                eng_pend = 1;
                done_at  = cyc + eng_lat;
                case (eng_fn)
                    0:       eng_res = modexp(Eng_msg, Eng_priv, Eng_pub);
                    1:       eng_res = Eng_msg + 16'd100;
                    default: eng_res = 16'd7;
                endcase
            end else if (eng_pend && cyc == done_at) begin
                Eng_done = 1;
                Eng_val  = eng_res;
                eng_pend = 0;
            end
        end
    end

    // Job-level model: age counts cycles since the start pulse.
    initial forever begin
        @(posedge Clk);
        if (Reset) begin
            m_job = 0; m_resp = 0; m_age = 0; m_grant = NREQ - 1;
            m_result = '0; m_err = 0; m_msg = '0; m_priv = '0; m_pub = '0;
        end else if (!m_job) begin
            if (Req != 0) begin
                m_grant = rr_next(m_grant, Req);
                m_msg = msg_a[m_grant]; m_priv = priv_a[m_grant]; m_pub = pub_a[m_grant];
                m_job = 1; m_age = 0;
            end
        end else if (m_resp) begin
            m_job = 0; m_resp = 0;
        end else if (m_age >= 1 && Eng_done) begin
            m_result = Eng_val; m_err = 0; m_resp = 1;
        end else if (m_age == TIMEOUT) begin
            m_result = '0; m_err = 1; m_resp = 1;
        end else begin
            m_age++;
        end
    end

    initial forever begin
        @(negedge Clk);
        if (chk_en) begin
            check("ack",       32'(Ack),       m_resp ? 32'(1 << m_grant) : 32'd0);
            check("busy",      32'(Busy),      32'(m_job));
            check("eng_start", 32'(Eng_start), 32'(m_job && !m_resp && m_age == 0));
            check("grant_id",  32'(Grant_id),  32'(m_grant));
            check("result",    32'(Result),    32'(m_result));
            check("err",       32'(Err),       32'(m_err));
            check("eng_msg",   32'(Eng_msg),   32'(m_msg));
            check("eng_priv",  32'(Eng_priv),  32'(m_priv));
            check("eng_pub",   32'(Eng_pub),   32'(m_pub));
        end
    end

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!Eng_start && n < 20);
        check("start_bound", 32'(Eng_start), 32'd1);
    endtask

    task automatic wait_ack(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (Ack == 0 && n < maxc);
        check("ack_bound", 32'(Ack != 0), 32'd1);
    endtask

    task automatic do_job(input logic [NREQ-1:0] req_v, input int lat, input int fn,
                          input bit drop, output int ns, output int na,
                          output logic [NREQ-1:0] a, output logic [W-1:0] r,
                          output logic e, output int gid);
        eng_lat = lat;
        eng_fn  = fn;
        Req     = req_v;
        wait_start(ns);
        gid = int'(Grant_id);
        wait_ack(TIMEOUT + 30, na);
        a = Ack; r = Result; e = Err;
        if (drop) Req = Req & ~Ack;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "bench stalled");
    end

    initial begin
        int ns, na, gid, acks;
        logic [NREQ-1:0] a;
        logic [W-1:0] r;
        logic e;
        logic [NREQ-1:0] rr_ack[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int rr_res[5] = '{102, 103, 104, 105, 102};

        Reset = 1; Req = '0; Msg_in = '0; Priv_in = '0; Pub_in = '0;
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 2), 16'd5, 16'd77);
        @(posedge Clk);
        chk_en = 1;
        @(negedge Clk);
        @(negedge Clk);
        check("rst_grant", 32'(Grant_id), 32'd3);
        check("rst_busy",  32'(Busy),     32'd0);
        check("rst_ack",   32'(Ack),      32'd0);
        Reset = 0;

        // single job: 9^3 mod 33 = 3
        set_ops(0, 16'd9, 16'd3, 16'd33);
        @(negedge Clk);
        eng_lat = 12; eng_fn = 0; Req = 4'b0001;
        wait_start(ns);
        check("single_start_lat", 32'(ns), 32'd1);
        check("single_msg",  32'(Eng_msg),  32'd9);
        check("single_priv", 32'(Eng_priv), 32'd3);
        check("single_pub",  32'(Eng_pub),  32'd33);
        wait_ack(40, na);
        check("single_ack_lat", 32'(na), 32'd13);
        check("single_ack", 32'(Ack), 32'b0001);
        check("single_res", 32'(Result), 32'd3);
        check("single_err", 32'(Err), 32'd0);
        check("model_single_res", 32'(m_result), 32'd3);
        Req = '0;

        // round robin from a fresh reset
        set_ops(0, 16'd2, 16'd5, 16'd77);
        Reset = 1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 0;
        for (int j = 0; j < 5; j++) begin
            do_job(4'b1111, 5, 1, 0, ns, na, a, r, e, gid);
            check("rr_grant", 32'(gid), 32'(j % NREQ));
            check("rr_ack", 32'(a), 32'(rr_ack[j]));
            check("rr_res", 32'(r), 32'(rr_res[j]));
        end
        Req = '0;

        // fairness skip: grant 1 first, then Req=1001 goes 3 then 0
        do_job(4'b0010, 4, 1, 1, ns, na, a, r, e, gid);
        check("skip_pre_grant", 32'(gid), 32'd1);
        do_job(4'b1001, 4, 1, 1, ns, na, a, r, e, gid);
        check("skip_grant_a", 32'(gid), 32'd3);
        check("skip_res_a", 32'(r), 32'd105);
        do_job(Req, 4, 1, 1, ns, na, a, r, e, gid);
        check("skip_grant_b", 32'(gid), 32'd0);
        check("skip_ack_b", 32'(a), 32'b0001);
        Req = '0;

        // timeout: engine silent
        do_job(4'b0100, 0, 1, 1, ns, na, a, r, e, gid);
        check("to_lat", 32'(na), 32'(TIMEOUT + 1));
        check("to_ack", 32'(a), 32'b0100);
        check("to_err", 32'(e), 32'd1);
        check("to_res", 32'(r), 32'd0);
        do_job(4'b0100, 4, 1, 1, ns, na, a, r, e, gid);
        check("post_to_err", 32'(e), 32'd0);
        check("post_to_res", 32'(r), 32'd104);

        // done arrives in the last watchdog cycle
        do_job(4'b1000, TIMEOUT, 2, 1, ns, na, a, r, e, gid);
        check("coll_lat", 32'(na), 32'(TIMEOUT + 1));
        check("coll_res", 32'(r), 32'd7);
        check("coll_err", 32'(e), 32'd0);

        // reset during WAIT
        eng_lat = 12; eng_fn = 1; Req = 4'b0010;
        wait_start(ns);
        repeat (5) @(negedge Clk);
        Reset = 1; Req = '0;
        @(negedge Clk);
        check("mid_rst_busy",  32'(Busy),     32'd0);
        check("mid_rst_ack",   32'(Ack),      32'd0);
        check("mid_rst_grant", 32'(Grant_id), 32'd3);
        check("mid_rst_msg",   32'(Eng_msg),  32'd0);
        check("mid_rst_res",   32'(Result),   32'd0);
        @(negedge Clk);
        Reset = 0;
        stray = 1;
        acks = 0;
        repeat (10) begin
            @(negedge Clk);
            if (Ack != 0) acks++;
        end
        check("stray_no_ack", 32'(acks), 32'd0);
        check("stray_res", 32'(Result), 32'd0);
        do_job(4'b0010, 3, 1, 1, ns, na, a, r, e, gid);
        check("post_rst_grant", 32'(gid), 32'd1);
        check("post_rst_ack", 32'(a), 32'b0010);
        check("post_rst_res", 32'(r), 32'd103);
        Req = '0;
        repeat (3) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
